memory_access: RTL and testbench

Memory (_m) pipeline stage of the RV32I core. It registers the execute-stage results and performs word loads and stores on a valid/ready data bus with a separate response channel. It raises `stall_m` to the hazard control unit while an access is outstanding. It also supplies `alu_res_m` forwarding to execute and load data to writeback.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/memory_access_if.sv | 25 ++
 rtl/dbus_ctrl.sv | 79 +++++++
 rtl/memory_access.sv | 120 ++++++++++++
 tb/tb_memory_access.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the RV32I pipeline.
// Holds write-back source codes, M-stage FSM states and the E->M control bundle.
package riscv_pkg;

  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RESP  = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       rd_write;
    logic       mem_write;
    logic [1:0] rd_write_src;
    logic [4:0] rd;
  } ex_mem_ctrl_t;

  function automatic logic is_mem_op(
    input ex_mem_ctrl_t c
  );
    return c.mem_write |
           (c.rd_write_src == SRC_MEM);
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if: word data bus, valid/ready request plus response channel.
// master drives req/we/addr/wdata; slave drives ready/rvalid/rdata.
interface memory_access_if #(
  parameter int XLEN = 32
) ();

  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: data-bus access FSM (IDLE/RESP/DRAIN) with done/stall logic.
// Ports: clk, rst, mem_op_i, store_i, flush_i, ready_i, rvalid_i ->
//        req_o, done_o, load_done_o, stall_o, drain_o.
module dbus_ctrl
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic mem_op_i,
  input  logic store_i,
  input  logic flush_i,
  input  logic ready_i,
  input  logic rvalid_i,
  output logic req_o,
  output logic done_o,
  output logic load_done_o,
  output logic stall_o,
  output logic drain_o
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       accept;
  logic       done;

  assign req_o  = (state_q == ST_IDLE) & mem_op_i;
  assign accept = req_o & ready_i;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (store_i || rvalid_i) begin
            done = 1'b1;
          end else if (flush_i) begin
            // load accepted but its slot is
            // being bubbled: drop the reply
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rvalid_i) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign done_o      = done;
  assign load_done_o = done & ~store_i;
  assign drain_o     = (state_q == ST_DRAIN);
  assign stall_o     = (mem_op_i & ~done) |
                       (state_q == ST_DRAIN);

endmodule

// File: rtl/memory_access.sv
// memory_access: M stage; registers E results and runs word loads/stores.
// Ports: clk, rst, *_e inputs, flush_m -> stall_m, *_m outputs, dbus master.
module memory_access
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write_e,
  input  logic            rd_write_e,
  input  logic            mem_write_e,
  input  logic [1:0]      rd_write_src_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] alu_res_e,
  input  logic [XLEN-1:0] mem_data_e,
  input  logic            flush_m,
  output logic            stall_m,
  output logic            pc_write_m,
  output logic            rd_write_m,
  output logic [1:0]      rd_write_src_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] pc_m,
  output logic [XLEN-1:0] alu_res_m,
  output logic [XLEN-1:0] read_data_m,
  memory_access_if.master dbus
);

  ex_mem_ctrl_t    ctrl_e;
  ex_mem_ctrl_t    ctrl_q;
  ex_mem_ctrl_t    ctrl_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] alu_d;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] wdata_d;

  logic mem_op;
  logic stall;
  logic done;
  logic load_done;
  logic drain;

  assign ctrl_e = {pc_write_e,
                   rd_write_e,
                   mem_write_e,
                   rd_write_src_e,
                   rd_e};

  assign mem_op = is_mem_op(ctrl_q);

  dbus_ctrl u_dbus_ctrl (
    .clk         (clk),
    .rst         (rst),
    .mem_op_i    (mem_op),
    .store_i     (ctrl_q.mem_write),
    .flush_i     (flush_m),
    .ready_i     (dbus.ready),
    .rvalid_i    (dbus.rvalid),
    .req_o       (dbus.req),
    .done_o      (done),
    .load_done_o (load_done),
    .stall_o     (stall),
    .drain_o     (drain)
  );

  // flush beats hold, except while draining:
  // the slot is already a bubble then
  always_comb begin
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    wdata_d = wdata_q;
    if (flush_m && !drain) begin
      ctrl_d  = '0;
      pc_d    = '0;
      alu_d   = '0;
      wdata_d = '0;
    end else if (!stall) begin
      ctrl_d  = ctrl_e;
      pc_d    = pc_e;
      alu_d   = alu_res_e;
      wdata_d = mem_data_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      wdata_q <= wdata_d;
    end
  end

  assign stall_m        = stall;
  assign pc_write_m     = ctrl_q.pc_write & ~stall;
  assign rd_write_m     = ctrl_q.rd_write & ~stall;
  assign rd_write_src_m = ctrl_q.rd_write_src;
  assign rd_m           = ctrl_q.rd;
  assign pc_m           = pc_q;
  assign alu_res_m      = alu_q;
  assign read_data_m    = load_done ? dbus.rdata
                                    : '0;

  assign dbus.we    = ctrl_q.mem_write;
  assign dbus.addr  = {alu_q[XLEN-1:2], 2'b00};
  assign dbus.wdata = wdata_q;

  logic unused_done;
  assign unused_done = done;

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: scoreboard bench for the M stage.
// Drives E-stage ops and a scripted data bus; compares M outputs.
module tb_memory_access;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write_e, rd_write_e, mem_write_e;
  logic [1:0]  rd_write_src_e;
  logic [4:0]  rd_e;
  logic [31:0] pc_e, alu_res_e, mem_data_e;
  logic        flush_m;
  logic        stall_m, pc_write_m, rd_write_m;
  logic [1:0]  rd_write_src_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_m, alu_res_m, read_data_m;

  memory_access_if #(.XLEN(32)) dbus ();

  memory_access #(.XLEN(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_write_e     (pc_write_e),
    .rd_write_e     (rd_write_e),
    .mem_write_e    (mem_write_e),
    .rd_write_src_e (rd_write_src_e),
    .rd_e           (rd_e),
    .pc_e           (pc_e),
    .alu_res_e      (alu_res_e),
    .mem_data_e     (mem_data_e),
    .flush_m        (flush_m),
    .stall_m        (stall_m),
    .pc_write_m     (pc_write_m),
    .rd_write_m     (rd_write_m),
    .rd_write_src_m (rd_write_src_m),
    .rd_m           (rd_m),
    .pc_m           (pc_m),
    .alu_res_m      (alu_res_m),
    .read_data_m    (read_data_m),
    .dbus           (dbus)
  );

  always #5 clk = ~clk;

  // kind: 0 alu, 1 load, 2 store, 3 bubble
  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic drive_e(input int k, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd);
    pc_write_e     = 1'b0;
    rd_write_e     = (k == 0) || (k == 1);
    mem_write_e    = (k == 2);
    rd_write_src_e = (k == 1) ? SRC_MEM : SRC_ALU;
    rd_e           = (k == 3) ? 5'd0 : rd;
    pc_e           = (k == 3) ? 32'd0 : $urandom;
    alu_res_e      = (k == 3) ? 32'd0 : a;
    mem_data_e     = (k == 2) ? d : 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_m = 1'b0;
    dbus.ready = 1'b0;
    dbus.rvalid = 1'b0;
    dbus.rdata = 32'hFFFF_FFFF;
    drive_e(3, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0h want 0", stall_m); end
    n_chk++; if (dbus.req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0h want 0", dbus.req); end
    n_chk++; if (rd_write_m !== 1'b0) begin n_fail++; $display("FAIL reset_rdw got %0h want 0", rd_write_m); end
    n_chk++; if (alu_res_m !== 32'd0) begin n_fail++; $display("FAIL reset_alu got %0h want 0", alu_res_m); end
    n_chk++; if (pc_m !== 32'd0) begin n_fail++; $display("FAIL reset_pc got %0h want 0", pc_m); end
    n_chk++; if (read_data_m !== 32'd0) begin n_fail++; $display("FAIL reset_rdata got %0h want 0", read_data_m); end
    n_chk++; if (dbus.addr !== 32'd0 || dbus.wdata !== 32'd0 || dbus.we !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus addr %0h wdata %0h we %0h want 0", dbus.addr, dbus.wdata, dbus.we); end
    rst = 1'b0;
  endtask

  task automatic test_alu();
    @(negedge clk);
    drive_e(0, 32'h1234, 0, 5'd7);
    pc_e = 32'h40;
    pc_write_e = 1'b1;
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    #1;
    n_chk++; if (alu_res_m !== 32'h1234) begin n_fail++; $display("FAIL alu_res got %0h want 1234", alu_res_m); end
    n_chk++; if (rd_write_m !== 1'b1) begin n_fail++; $display("FAIL alu_rdw got %0h want 1", rd_write_m); end
    n_chk++; if (rd_m !== 5'd7) begin n_fail++; $display("FAIL alu_rd got %0d want 7", rd_m); end
    n_chk++; if (pc_m !== 32'h40 || pc_write_m !== 1'b1) begin
      n_fail++; $display("FAIL alu_pc got %0h/%0h want 40/1", pc_m, pc_write_m); end
    n_chk++; if (dbus.req !== 1'b0 || stall_m !== 1'b0) begin
      n_fail++; $display("FAIL alu_req got %0h stall %0h want 0/0", dbus.req, stall_m); end
    @(negedge clk);
    #1;
    n_chk++; if (rd_write_m !== 1'b0) begin n_fail++; $display("FAIL alu_bubble got %0h want 0", rd_write_m); end
  endtask

  task automatic test_store();
    @(negedge clk);
    drive_e(2, 32'h100, 32'hDEADBEEF, 0);
    sb.push_back('{2, 32'h100, 32'hDEADBEEF, 5'd0});
    dbus.ready = 1'b1;
    dbus.rvalid = 1'b0;
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    #1;
    e = sb.pop_front();
    n_chk++; if (dbus.req !== 1'b1 || dbus.we !== 1'b1) begin
      n_fail++; $display("FAIL st_req got %0h we %0h want 1/1", dbus.req, dbus.we); end
    n_chk++; if (dbus.addr !== e.a) begin n_fail++; $display("FAIL st_addr got %0h want %0h", dbus.addr, e.a); end
    n_chk++; if (dbus.wdata !== e.d) begin n_fail++; $display("FAIL st_wdata got %0h want %0h", dbus.wdata, e.d); end
    n_chk++; if (stall_m !== 1'b0 || rd_write_m !== 1'b0) begin
      n_fail++; $display("FAIL st_stall got %0h rdw %0h want 0/0", stall_m, rd_write_m); end
    @(negedge clk);
    #1;
    n_chk++; if (dbus.req !== 1'b0) begin n_fail++; $display("FAIL st_req_drop got %0h want 0", dbus.req); end
  endtask

  task automatic test_load_wait();
    int stalls;
    stalls = 0;
    @(negedge clk);
    drive_e(1, 32'h200, 0, 5'd5);
    sb.push_back('{1, 32'h200, 32'hCAFE0001, 5'd5});
    dbus.ready = 1'b0;
    dbus.rvalid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      drive_e(3, 0, 0, 0);
      dbus.ready = (c >= 3);
      dbus.rvalid = (c == 5);
      dbus.rdata = (c == 5) ? sb[0].d : 32'h0BAD_0000 + c;
      #1;
      if (stall_m) stalls++;
      if (c < 5) begin
        n_chk++; if (rd_write_m !== 1'b0 || read_data_m !== 32'd0) begin
          n_fail++; $display("FAIL ldw_early c%0d rdw %0h data %0h want 0/0", c, rd_write_m, read_data_m); end
      end
      if (c == 3) begin
        n_chk++; if (dbus.req !== 1'b1 || dbus.we !== 1'b0 || dbus.addr !== sb[0].a) begin
          n_fail++; $display("FAIL ldw_req req %0h we %0h addr %0h want 1/0/%0h", dbus.req, dbus.we, dbus.addr, sb[0].a); end
      end
    end
    e = sb.pop_front();
    n_chk++; if (stalls != 4) begin n_fail++; $display("FAIL ldw_stalls got %0d want 4", stalls); end
    n_chk++; if (read_data_m !== e.d) begin n_fail++; $display("FAIL ldw_data got %0h want %0h", read_data_m, e.d); end
    n_chk++; if (rd_write_m !== 1'b1 || rd_m !== e.rd) begin
      n_fail++; $display("FAIL ldw_wb rdw %0h rd %0d want 1/%0d", rd_write_m, rd_m, e.rd); end
    @(negedge clk);
    dbus.ready = 1'b0;
    dbus.rvalid = 1'b0;
    #1;
    n_chk++; if (rd_write_m !== 1'b0 || read_data_m !== 32'd0) begin
      n_fail++; $display("FAIL ldw_after rdw %0h data %0h want 0/0", rd_write_m, read_data_m); end
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    drive_e(1, 32'h103, 0, 5'd3);
    sb.push_back('{1, 32'h103, 32'h55AA_0102, 5'd3});
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    dbus.ready = 1'b1;
    dbus.rvalid = 1'b1;
    dbus.rdata = sb[0].d;
    #1;
    e = sb.pop_front();
    n_chk++; if (dbus.addr !== 32'h100) begin n_fail++; $display("FAIL mis_addr got %0h want 100", dbus.addr); end
    n_chk++; if (stall_m !== 1'b0 || read_data_m !== e.d) begin
      n_fail++; $display("FAIL mis_zw stall %0h data %0h want 0/%0h", stall_m, read_data_m, e.d); end
    n_chk++; if (rd_write_m !== 1'b1 || rd_write_src_m !== SRC_MEM) begin
      n_fail++; $display("FAIL mis_wb rdw %0h src %0h want 1/1", rd_write_m, rd_write_src_m); end
    @(negedge clk);
    dbus.ready = 1'b0;
    dbus.rvalid = 1'b0;
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    drive_e(1, 32'h400, 0, 5'd4);
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    flush_m = 1'b1;
    #1;
    n_chk++; if (dbus.req !== 1'b1 || stall_m !== 1'b1) begin
      n_fail++; $display("FAIL fi_pending req %0h stall %0h want 1/1", dbus.req, stall_m); end
    @(negedge clk);
    flush_m = 1'b0;
    dbus.ready = 1'b1;
    dbus.rvalid = 1'b1;
    dbus.rdata = 32'h77;
    #1;
    n_chk++; if (dbus.req !== 1'b0 || stall_m !== 1'b0) begin
      n_fail++; $display("FAIL fi_drop req %0h stall %0h want 0/0", dbus.req, stall_m); end
    n_chk++; if (rd_write_m !== 1'b0 || read_data_m !== 32'd0) begin
      n_fail++; $display("FAIL fi_wb rdw %0h data %0h want 0/0", rd_write_m, read_data_m); end
    @(negedge clk);
    dbus.ready = 1'b0;
    dbus.rvalid = 1'b0;
  endtask

  task automatic test_flush_resp();
    @(negedge clk);
    drive_e(1, 32'h300, 0, 5'd9);
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    dbus.ready = 1'b1;
    #1;
    n_chk++; if (dbus.req !== 1'b1 || stall_m !== 1'b1) begin
      n_fail++; $display("FAIL fr_accept req %0h stall %0h want 1/1", dbus.req, stall_m); end
    @(negedge clk);
    dbus.ready = 1'b0;
    flush_m = 1'b1;
    #1;
    n_chk++; if (stall_m !== 1'b1) begin n_fail++; $display("FAIL fr_resp stall %0h want 1", stall_m); end
    @(negedge clk);
    flush_m = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_chk++; if (stall_m !== 1'b1 || rd_write_m !== 1'b0 || dbus.req !== 1'b0) begin
        n_fail++; $display("FAIL fr_drain%0d stall %0h rdw %0h req %0h want 1/0/0", c, stall_m, rd_write_m, dbus.req); end
      @(negedge clk);
    end
    dbus.rvalid = 1'b1;
    dbus.rdata = 32'hBAD;
    #1;
    n_chk++; if (stall_m !== 1'b1 || rd_write_m !== 1'b0 || read_data_m !== 32'd0) begin
      n_fail++; $display("FAIL fr_rvalid stall %0h rdw %0h data %0h want 1/0/0", stall_m, rd_write_m, read_data_m); end
    @(negedge clk);
    dbus.rvalid = 1'b0;
    drive_e(0, 32'h55, 0, 5'd2);
    #1;
    n_chk++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL fr_idle stall %0h want 0", stall_m); end
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    #1;
    n_chk++; if (alu_res_m !== 32'h55 || rd_write_m !== 1'b1) begin
      n_fail++; $display("FAIL fr_next alu %0h rdw %0h want 55/1", alu_res_m, rd_write_m); end
  endtask

  task automatic test_reset_resp();
    @(negedge clk);
    drive_e(1, 32'h500, 0, 5'd6);
    @(negedge clk);
    drive_e(3, 0, 0, 0);
    dbus.ready = 1'b1;
    @(negedge clk);
    dbus.ready = 1'b0;
    rst = 1'b1;
    #1;
    n_chk++; if (stall_m !== 1'b1) begin n_fail++; $display("FAIL rr_resp stall %0h want 1", stall_m); end
    @(negedge clk);
    rst = 1'b0;
    dbus.rvalid = 1'b1;
    dbus.rdata = 32'h1111;
    #1;
    n_chk++; if (stall_m !== 1'b0 || dbus.req !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle stall %0h req %0h want 0/0", stall_m, dbus.req); end
    n_chk++; if (rd_write_m !== 1'b0 || read_data_m !== 32'd0 || rd_m !== 5'd0 || alu_res_m !== 32'd0) begin
      n_fail++; $display("FAIL rr_stale rdw %0h data %0h rd %0d alu %0h want 0", rd_write_m, read_data_m, rd_m, alu_res_m); end
    @(negedge clk);
    dbus.rvalid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int k;
    logic [31:0] a, d;
    logic [4:0] rd;
    dbus.ready = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      @(negedge clk);
      dbus.rvalid = (sb.size() > 0) && (sb[0].kind == 1);
      dbus.rdata = (sb.size() > 0) ? sb[0].d : 32'd0;
      if (i < 24) begin
        k = $urandom_range(0, 2);
        a = $urandom;
        d = $urandom;
        rd = 5'($urandom_range(1, 31));
        drive_e(k, a, d, rd);
        sb.push_back('{k, a, d, rd});
      end else begin
        drive_e(3, 0, 0, 0);
      end
      #1;
      if (i > 0) begin
        e = sb.pop_front();
        n_chk++; if (stall_m !== 1'b0) begin n_fail++; $display("FAIL b2b%0d stall %0h want 0", i, stall_m); end
        if (e.kind == 0) begin
          n_chk++; if (dbus.req !== 1'b0 || alu_res_m !== e.a || rd_write_m !== 1'b1 || rd_m !== e.rd) begin
            n_fail++; $display("FAIL b2b%0d alu req %0h alu %0h rdw %0h rd %0d want 0/%0h/1/%0d",
                               i, dbus.req, alu_res_m, rd_write_m, rd_m, e.a, e.rd); end
        end else if (e.kind == 1) begin
          n_chk++; if (dbus.req !== 1'b1 || dbus.we !== 1'b0 || dbus.addr !== {e.a[31:2], 2'b00} ||
                       read_data_m !== e.d || rd_write_m !== 1'b1 || rd_m !== e.rd) begin
            n_fail++; $display("FAIL b2b%0d load req %0h we %0h addr %0h data %0h rdw %0h want 1/0/%0h/%0h/1",
                               i, dbus.req, dbus.we, dbus.addr, read_data_m, rd_write_m, {e.a[31:2], 2'b00}, e.d); end
        end else begin
          n_chk++; if (dbus.req !== 1'b1 || dbus.we !== 1'b1 || dbus.addr !== {e.a[31:2], 2'b00} ||
                       dbus.wdata !== e.d || rd_write_m !== 1'b0) begin
            n_fail++; $display("FAIL b2b%0d store req %0h we %0h addr %0h wdata %0h rdw %0h want 1/1/%0h/%0h/0",
                               i, dbus.req, dbus.we, dbus.addr, dbus.wdata, rd_write_m, {e.a[31:2], 2'b00}, e.d); end
        end
      end
    end
    n_chk++; if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_left got %0d want 0", sb.size()); end
    @(negedge clk);
    dbus.ready = 1'b0;
    dbus.rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load_wait();
    test_misaligned();
    test_flush_idle();
    test_flush_resp();
    test_reset_resp();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
